// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU/compare slice.
// Holds ALU op encodings, branch opcodes and REGIMM rt codes.
package alu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [5:0] {
        OP_AND   = 6'h00,
        OP_OR    = 6'h01,
        OP_XOR   = 6'h02,
        OP_NOR   = 6'h03,
        OP_ADD   = 6'h04,
        OP_SUB   = 6'h05,
        OP_SLT   = 6'h06,
        OP_SLTU  = 6'h07,
        OP_SLL   = 6'h08,
        OP_SRL   = 6'h09,
        OP_SRA   = 6'h0A,
        OP_SLLV  = 6'h0B,
        OP_SRLV  = 6'h0C,
        OP_SRAV  = 6'h0D,
        OP_LUI   = 6'h0E,
        OP_MULT  = 6'h0F,
        OP_MULTU = 6'h10,
        OP_DIV   = 6'h11,
        OP_DIVU  = 6'h12,
        OP_MFHI  = 6'h13,
        OP_MFLO  = 6'h14,
        OP_MTHI  = 6'h15,
        OP_MTLO  = 6'h16,
        OP_PASSA = 6'h17
    } alu_op_e;

    localparam logic [5:0] OPC_REGIMM = 6'h01;
    localparam logic [5:0] OPC_BEQ    = 6'h04;
    localparam logic [5:0] OPC_BNE    = 6'h05;
    localparam logic [5:0] OPC_BLEZ   = 6'h06;
    localparam logic [5:0] OPC_BGTZ   = 6'h07;

    localparam logic [4:0] RT_BLTZ   = 5'h00;
    localparam logic [4:0] RT_BGEZ   = 5'h01;
    localparam logic [4:0] RT_BLTZAL = 5'h10;
    localparam logic [4:0] RT_BGEZAL = 5'h11;

    typedef struct packed {
        logic            hi_we;
        logic            lo_we;
        logic [XLEN-1:0] hi;
        logic [XLEN-1:0] lo;
    } hilo_upd_t;

    function automatic logic [XLEN-1:0] lui_val(input logic [XLEN-1:0] b);
        return {b[15:0], 16'h0000};
    endfunction

endpackage

// File: rtl/alu_compare_if.sv
// Operand/control bundle between issue logic and the ALU/compare unit.
// The master drives operands; the slave returns result, HI/LO and taken.
interface alu_compare_if;
    import alu_pkg::*;

    logic            valid_in;
    logic [5:0]      alu_control;
    logic [4:0]      shift_amount;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] instr;
    logic            jump;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] hi_out;
    logic [XLEN-1:0] lo_out;
    logic            taken;

    modport master (
        output valid_in, alu_control, shift_amount,
        output op_a, op_b, instr, jump,
        input  alu_result, hi_out, lo_out, taken
    );

    modport slave (
        input  valid_in, alu_control, shift_amount,
        input  op_a, op_b, instr, jump,
        output alu_result, hi_out, lo_out, taken
    );

endinterface

// File: rtl/branch_cmp.sv
// Combinational branch/jump decision from opcode, rt and operands.
// Jumps always win; otherwise opcode and REGIMM rt pick the test.
module branch_cmp
    import alu_pkg::*;
(
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [5:0]      opcode,
    input  logic [4:0]      rt,
    input  logic            jump,
    output logic            taken
);

    logic eq;
    logic a_neg;
    logic a_zero;

    assign eq     = (op_a == op_b);
    assign a_neg  = op_a[XLEN-1];
    assign a_zero = (op_a == '0);

    always_comb begin
        taken = 1'b0;
        if (jump) begin
            taken = 1'b1;
        end else begin
            unique case (opcode)
                OPC_BEQ:  taken = eq;
                OPC_BNE:  taken = !eq;
                OPC_BLEZ: taken = a_neg || a_zero;
                OPC_BGTZ: taken = !a_neg && !a_zero;
                OPC_REGIMM: begin
                    unique case (rt)
                        RT_BLTZ, RT_BLTZAL: taken = a_neg;
                        RT_BGEZ, RT_BGEZAL: taken = !a_neg;
                        default:            taken = 1'b0;
                    endcase
                end
                default: taken = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/alu_compare.sv
// ALU datapath with HI/LO multiply/divide registers and branch compare.
// Result and taken are combinational; HI/LO update one cycle later.
module alu_compare
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic         CLK,
    input  logic         RESET,
    alu_compare_if.slave bus
);

    logic [DATA_W-1:0]   a;
    logic [DATA_W-1:0]   b;
    logic [4:0]          sh_imm;
    logic [4:0]          sh_var;
    logic [DATA_W-1:0]   hi_q;
    logic [DATA_W-1:0]   lo_q;
    logic [DATA_W-1:0]   res;
    logic [2*DATA_W-1:0] prod_s;
    logic [2*DATA_W-1:0] prod_u;
    logic [DATA_W-1:0]   q_s;
    logic [DATA_W-1:0]   r_s;
    logic [DATA_W-1:0]   q_u;
    logic [DATA_W-1:0]   r_u;
    logic                div_zero;
    logic                div_ovf;
    logic                taken_w;
    hilo_upd_t           upd;
    logic                unused_instr;

    assign a      = bus.op_a;
    assign b      = bus.op_b;
    assign sh_imm = bus.shift_amount;
    assign sh_var = a[4:0];

    assign unused_instr = ^{bus.instr[25:21], bus.instr[15:0]};

    // Low 64 bits of the sign-extended product equal the signed product.
    assign prod_s = {{DATA_W{a[DATA_W-1]}}, a} *
                    {{DATA_W{b[DATA_W-1]}}, b};
    assign prod_u = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};

    assign div_zero = (b == '0);
    assign div_ovf  = (a == {1'b1, {(DATA_W-1){1'b0}}}) && (b == '1);

    always_comb begin
        q_s = '0;
        r_s = '0;
        q_u = '0;
        r_u = '0;
        if (!div_zero) begin
            q_u = a / b;
            r_u = a % b;
            if (div_ovf) begin
                q_s = a;
                r_s = '0;
            end else begin
                q_s = $signed(a) / $signed(b);
                r_s = $signed(a) % $signed(b);
            end
        end
    end

    always_comb begin
        upd = '0;
        case (bus.alu_control)
            OP_MULT: begin
                upd.hi_we = 1'b1;
                upd.lo_we = 1'b1;
                upd.hi    = prod_s[2*DATA_W-1:DATA_W];
                upd.lo    = prod_s[DATA_W-1:0];
            end
            OP_MULTU: begin
                upd.hi_we = 1'b1;
                upd.lo_we = 1'b1;
                upd.hi    = prod_u[2*DATA_W-1:DATA_W];
                upd.lo    = prod_u[DATA_W-1:0];
            end
            OP_DIV: begin
                upd.hi_we = !div_zero;
                upd.lo_we = !div_zero;
                upd.hi    = r_s;
                upd.lo    = q_s;
            end
            OP_DIVU: begin
                upd.hi_we = !div_zero;
                upd.lo_we = !div_zero;
                upd.hi    = r_u;
                upd.lo    = q_u;
            end
            OP_MTHI: begin
                upd.hi_we = 1'b1;
                upd.hi    = a;
            end
            OP_MTLO: begin
                upd.lo_we = 1'b1;
                upd.lo    = a;
            end
            default: upd = '0;
        endcase
    end

    always_comb begin
        res = '0;
        case (bus.alu_control)
            OP_AND:   res = a & b;
            OP_OR:    res = a | b;
            OP_XOR:   res = a ^ b;
            OP_NOR:   res = ~(a | b);
            OP_ADD:   res = a + b;
            OP_SUB:   res = a - b;
            OP_SLT:   res = {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU:  res = {{(DATA_W-1){1'b0}}, a < b};
            OP_SLL:   res = b << sh_imm;
            OP_SRL:   res = b >> sh_imm;
            OP_SRA:   res = $signed(b) >>> sh_imm;
            OP_SLLV:  res = b << sh_var;
            OP_SRLV:  res = b >> sh_var;
            OP_SRAV:  res = $signed(b) >>> sh_var;
            OP_LUI:   res = lui_val(b);
            OP_MFHI:  res = hi_q;
            OP_MFLO:  res = lo_q;
            OP_PASSA: res = a;
            default:  res = '0;
        endcase
    end

    // Reset wins over any HI/LO write in the same cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (bus.valid_in) begin
            if (upd.hi_we) hi_q <= upd.hi;
            if (upd.lo_we) lo_q <= upd.lo;
        end
    end

    branch_cmp u_branch_cmp (
        .op_a   (a),
        .op_b   (b),
        .opcode (bus.instr[31:26]),
        .rt     (bus.instr[20:16]),
        .jump   (bus.jump),
        .taken  (taken_w)
    );

    assign bus.alu_result = res;
    assign bus.hi_out     = hi_q;
    assign bus.lo_out     = lo_q;
    assign bus.taken      = taken_w;

endmodule

// File: tb/tb_alu_compare.sv
// Self-checking bench for alu_compare: vector table plus HI/LO sequences.
// Expected values are queued at drive time and popped when sampled.
module tb_alu_compare;
    import alu_pkg::*;

    logic clk;
    logic rst;

    alu_compare_if bus ();

    alu_compare #(.DATA_W(32)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [5:0]  ctl;
        logic [4:0]  sh;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] instr;
        logic        jump;
        logic [31:0] exp_res;
        logic        exp_taken;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   n_vec;
    int   n_err;

    task automatic add(input string n, input logic [5:0] ctl,
                       input logic [4:0] sh, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] instr,
                       input logic jump, input logic [31:0] er,
                       input logic et);
        vec_t v;
        v.name = n; v.ctl = ctl; v.sh = sh; v.a = a; v.b = b;
        v.instr = instr; v.jump = jump; v.exp_res = er; v.exp_taken = et;
        vecs.push_back(v);
    endtask

    task automatic expect_val(input string n, input logic [31:0] e);
        sb_t s;
        s.name = n;
        s.exp  = e;
        sb.push_back(s);
    endtask

    task automatic check(input logic [31:0] act);
        sb_t s;
        n_vec++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL sb_empty: got %h with nothing expected", act);
        end else begin
            s = sb.pop_front();
            if (act !== s.exp) begin
                n_err++;
                $display("FAIL %s: got %h want %h", s.name, act, s.exp);
            end
        end
    endtask

    task automatic drive(input logic [5:0] ctl, input logic [4:0] sh,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] instr, input logic jump,
                         input logic valid);
        bus.alu_control  = ctl;
        bus.shift_amount = sh;
        bus.op_a         = a;
        bus.op_b         = b;
        bus.instr        = instr;
        bus.jump         = jump;
        bus.valid_in     = valid;
    endtask

    // Combinational step: check result/taken mid-cycle, end at posedge+1.
    task automatic comb_step(input string n, input logic [5:0] ctl,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] er, input logic jump,
                             input logic et);
        drive(ctl, 5'd0, a, b, 32'h0, jump, 1'b0);
        expect_val({n, "_res"}, er);
        expect_val({n, "_taken"}, {31'b0, et});
        @(negedge clk);
        check(bus.alu_result);
        check({31'b0, bus.taken});
        @(posedge clk);
        #1;
    endtask

    // HI/LO step: drive op, check registers just after the next edge.
    task automatic hl_step(input string n, input logic [5:0] ctl,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic valid, input logic [31:0] ehi,
                           input logic [31:0] elo);
        drive(ctl, 5'd0, a, b, 32'h0, 1'b0, valid);
        expect_val({n, "_hi"}, ehi);
        expect_val({n, "_lo"}, elo);
        @(posedge clk);
        #1;
        check(bus.hi_out);
        check(bus.lo_out);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        drive(6'h00, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

        add("add_ovf", OP_ADD, 0, 32'h7FFFFFFF, 32'h1, 0, 0, 32'h80000000, 0);
        add("sub_wrap", OP_SUB, 0, 32'h0, 32'h1, 0, 0, 32'hFFFFFFFF, 0);
        add("slt", OP_SLT, 0, 32'hFFFFFFFF, 32'h1, 0, 0, 32'h1, 0);
        add("sltu", OP_SLTU, 0, 32'hFFFFFFFF, 32'h1, 0, 0, 32'h0, 0);
        add("sra", OP_SRA, 4, 32'h0, 32'h80000000, 0, 0, 32'hF8000000, 0);
        add("and", OP_AND, 0, 32'hF0F0F0F0, 32'hFF00FF00, 0, 0, 32'hF000F000, 0);
        add("or", OP_OR, 0, 32'hF0F0F0F0, 32'hFF00FF00, 0, 0, 32'hFFF0FFF0, 0);
        add("xor", OP_XOR, 0, 32'hF0F0F0F0, 32'hFF00FF00, 0, 0, 32'h0FF00FF0, 0);
        add("nor", OP_NOR, 0, 32'hF0F0F0F0, 32'hFF00FF00, 0, 0, 32'h000F000F, 0);
        add("sll31", OP_SLL, 31, 32'h0, 32'h1, 0, 0, 32'h80000000, 0);
        add("srl31", OP_SRL, 31, 32'h0, 32'h80000000, 0, 0, 32'h1, 0);
        add("sllv", OP_SLLV, 0, 32'h21, 32'h3, 0, 0, 32'h6, 0);
        add("srav", OP_SRAV, 0, 32'h4, 32'h80000000, 0, 0, 32'hF8000000, 0);
        add("srlv", OP_SRLV, 0, 32'h4, 32'h80000000, 0, 0, 32'h08000000, 0);
        add("lui", OP_LUI, 0, 32'h0, 32'hABCD1234, 0, 0, 32'h12340000, 0);
        add("passa", OP_PASSA, 0, 32'hDEADBEEF, 32'h0, 0, 0, 32'hDEADBEEF, 0);
        add("bad_op", 6'h3F, 0, 32'h5, 32'h6, 0, 0, 32'h0, 0);
        add("mult_res", OP_MULT, 0, 32'h5, 32'h6, 0, 0, 32'h0, 0);
        add("mthi_res", OP_MTHI, 0, 32'h5, 32'h6, 0, 0, 32'h0, 0);
        add("beq", OP_PASSA, 0, 32'h5, 32'h5, 32'h10220005, 0, 32'h5, 1);
        add("beq_ne", OP_PASSA, 0, 32'h5, 32'h6, 32'h10220005, 0, 32'h5, 0);
        add("bne", OP_PASSA, 0, 32'h5, 32'h6, 32'h14220005, 0, 32'h5, 1);
        add("bgez0", OP_PASSA, 0, 32'h0, 32'h0, 32'h04010000, 0, 32'h0, 1);
        add("bgtz0", OP_PASSA, 0, 32'h0, 32'h0, 32'h1C000000, 0, 32'h0, 0);
        add("blez0", OP_PASSA, 0, 32'h0, 32'h0, 32'h18000000, 0, 32'h0, 1);
        add("bltz", OP_PASSA, 0, 32'hFFFFFFFF, 32'h0, 32'h04000000, 0, 32'hFFFFFFFF, 1);
        add("bltzal", OP_PASSA, 0, 32'h1, 32'h0, 32'h04100000, 0, 32'h1, 0);
        add("bgezal", OP_PASSA, 0, 32'h1, 32'h0, 32'h04110000, 0, 32'h1, 1);
        add("regimm_x", OP_PASSA, 0, 32'h1, 32'h0, 32'h04020000, 0, 32'h1, 0);
        add("op_j_nojump", OP_PASSA, 0, 32'h3, 32'h3, 32'h08000000, 0, 32'h3, 0);
        add("jump", OP_PASSA, 0, 32'h3, 32'h4, 32'hFFFFFFFF, 1, 32'h3, 1);

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        expect_val("rst_hi", 32'h0);
        expect_val("rst_lo", 32'h0);
        check(bus.hi_out);
        check(bus.lo_out);
        comb_step("rst_mfhi", OP_MFHI, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            drive(vecs[i].ctl, vecs[i].sh, vecs[i].a, vecs[i].b,
                  vecs[i].instr, vecs[i].jump, 1'b0);
            expect_val({vecs[i].name, "_res"}, vecs[i].exp_res);
            expect_val({vecs[i].name, "_taken"}, {31'b0, vecs[i].exp_taken});
            @(negedge clk);
            check(bus.alu_result);
            check({31'b0, bus.taken});
            @(posedge clk);
            #1;
        end

        // Table ran with valid_in=0, so HI/LO must still be zero.
        hl_step("idle", OP_MULT, 32'h5, 32'h6, 1'b0, 32'h0, 32'h0);
        hl_step("mult", OP_MULT, 32'hFFFFFFFE, 32'h3, 1'b1,
                32'hFFFFFFFF, 32'hFFFFFFFA);
        hl_step("multu", OP_MULTU, 32'hFFFFFFFE, 32'h3, 1'b1,
                32'h2, 32'hFFFFFFFA);
        hl_step("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1,
                32'hFFFFFFFE, 32'h00000001);
        hl_step("div_neg", OP_DIV, 32'hFFFFFFF9, 32'h2, 1'b1,
                32'hFFFFFFFF, 32'hFFFFFFFD);
        hl_step("div_zero", OP_DIV, 32'h1234, 32'h0, 1'b1,
                32'hFFFFFFFF, 32'hFFFFFFFD);
        hl_step("divu", OP_DIVU, 32'h7, 32'h2, 1'b1, 32'h1, 32'h3);
        hl_step("divu_zero", OP_DIVU, 32'h9, 32'h0, 1'b1, 32'h1, 32'h3);
        hl_step("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b1,
                32'h0, 32'h80000000);
        hl_step("mthi_inval", OP_MTHI, 32'h1234, 32'h0, 1'b0,
                32'h0, 32'h80000000);
        hl_step("mthi", OP_MTHI, 32'h1234, 32'h0, 1'b1,
                32'h1234, 32'h80000000);
        comb_step("mfhi_next", OP_MFHI, 32'h0, 32'h0, 32'h1234, 1'b0, 1'b0);
        hl_step("mtlo", OP_MTLO, 32'h55, 32'h0, 1'b1, 32'h1234, 32'h55);
        comb_step("mflo_next", OP_MFLO, 32'h0, 32'h0, 32'h55, 1'b0, 1'b0);
        hl_step("div_pre_rst", OP_DIV, 32'hFFFFFFF9, 32'h2, 1'b1,
                32'hFFFFFFFF, 32'hFFFFFFFD);

        rst = 1'b1;
        hl_step("rst_vs_mult", OP_MULT, 32'h2, 32'h3, 1'b1, 32'h0, 32'h0);
        comb_step("add_in_rst", OP_ADD, 32'h2, 32'h3, 32'h5, 1'b1, 1'b1);
        rst = 1'b0;
        comb_step("mflo_post_rst", OP_MFLO, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_leftover: got %0d entries want 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_compare.md
ALU_COMPARE -- requirements
Module: alu_compare

Interface
REQ-001 SHALL have parameter: DATA_W, 32, operand/result width; only 32 is supported.
REQ-002 SHALL have port: CLK  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port: RESET  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: valid_in  input  1  qualifies the current op for HI/LO updates.
REQ-005 SHALL have port: alu_control  input  6  operation select (encoding in REQ-013).
REQ-006 SHALL have port: shift_amount  input  5  shamt for immediate shifts.
REQ-007 SHALL have ports: op_a, op_b  input  32 each  operands A (rs) and B (rt/immediate).
REQ-008 SHALL have port: instr  input  32  instruction word used by branch compare.
REQ-009 SHALL have port: jump  input  1  unconditional jump/jr flag.
REQ-010 SHALL have port: alu_result  output  32  combinational result.
REQ-011 SHALL have ports: hi_out, lo_out  output  32 each  registered HI/LO contents.
REQ-012 SHALL have port: taken  output  1  combinational branch/jump decision.

Function
REQ-013 alu_result SHALL be combinational from current inputs and registered HI/LO, per alu_control:
- 00 AND; 01 OR; 02 XOR; 03 NOR.
- 04 ADD; 05 SUB; both modulo 2^32, no overflow trap.
- 06 SLT, signed; 07 SLTU, unsigned; result 1 or 0.
- 08 SLL, B<<shift_amount; 09 SRL; 0A SRA.
- 0B SLLV; 0C SRLV; 0D SRAV; shift B by A[4:0].
- 0E LUI, {B[15:0],16'h0}.
- 0F MULT; 10 MULTU; 11 DIV; 12 DIVU.
- 13 MFHI, returns HI; 14 MFLO, returns LO.
- 15 MTHI; 16 MTLO.
- 17 PASSA, returns A.
- any other code: result 0.
REQ-014 For codes 0F-12 and 15-16, alu_result SHALL be 0.
REQ-015 HI/LO SHALL change only at a CLK rising edge with valid_in=1 and RESET=0.
REQ-016 HI/LO updates, one-cycle latency:
- MULT/MULTU: {HI,LO} = 64-bit signed/unsigned product.
- DIV/DIVU: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
- MTHI: HI=A. MTLO: LO=A.
REQ-017 Divide by zero SHALL leave HI and LO unchanged.
REQ-018 Signed DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-019 A MFHI/MFLO issued in the cycle after a HI/LO-writing op SHALL return the new value.
REQ-020 taken SHALL be 1 whenever jump=1.
REQ-021 When jump=0, taken SHALL decode instr[31:26] (op) and instr[20:16] (rt):
- op 04 BEQ: A==B.
- op 05 BNE: A!=B.
- op 06 BLEZ: signed A<=0.
- op 07 BGTZ: signed A>0.
- op 01 with rt 00 BLTZ or 10 BLTZAL: A<0.
- op 01 with rt 01 BGEZ or 11 BGEZAL: A>=0.
- anything else: taken=0.
REQ-022 taken SHALL be independent of valid_in and of HI/LO.

Reset
REQ-023 RESET=1 at a CLK rising edge SHALL clear HI and LO to 0, taking priority over any simultaneous HI/LO write.
REQ-024 During reset, alu_result and taken SHALL remain combinational functions of the inputs; MFHI/MFLO return 0 after the reset edge.

Structure
REQ-025 The alu_control encodings, branch opcode values and REGIMM rt values SHALL be constants in the shared package alu_pkg.
REQ-026 Branch decode SHALL be one sub-module, branch_cmp, purely combinational.
REQ-027 The ALU datapath and the HI/LO registers SHALL reside in alu_compare.

Verification
REQ-028 A=0x7FFFFFFF, B=1, ADD -> alu_result=0x80000000; SUB with A=0, B=1 -> 0xFFFFFFFF.
REQ-029 A=0xFFFFFFFF, B=1: SLT -> 1, SLTU -> 0; B=0x80000000, SRA shamt 4 -> 0xF8000000.
REQ-030 MULT A=0xFFFFFFFE, B=3, valid -> next cycle HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU with the same operands -> HI=2, LO=0xFFFFFFFA.
REQ-031 DIV A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; then DIV with B=0 -> HI/LO unchanged; then RESET -> HI=LO=0.
REQ-032 BEQ instr 0x10220005 with A=B=5 -> taken=1; BGEZ with A=0 -> 1; BGTZ with A=0 -> 0; jump=1 with any instr -> 1.
REQ-033 MTHI A=0x1234 with valid_in=0 -> HI unchanged; same op with valid_in=1 -> next-cycle MFHI returns 0x1234.
